// File: rtl/rom_boot_copier.sv
// rom_boot_copier: boot-time copy engine between the program ROM and RAM.
// Streams every ROM byte into the RAM write port, optionally checks the
// 4-byte image header, and releases the CPU reset only after a clean copy.
module rom_boot_copier #(
    parameter int                    ROM_ADDR_W  = 7,
    parameter int                    ROM_SIZE    = 128,
    parameter int                    RAM_ADDR_W  = 16,
    parameter logic [RAM_ADDR_W-1:0] RAM_BASE    = '0,
    parameter bit                    CHECK_MAGIC = 1'b1,
    parameter logic [31:0]           MAGIC       = 32'h4153524D
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  rom_enable,
    input  logic [7:0]            rom_data,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_data,
    output logic                  ram_write,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    // The counter must reach ROM_SIZE itself (the final write-only cycle),
    // so it is one bit wider than the ROM address.
    localparam int                    CNT_W      = ROM_ADDR_W + 1;
    localparam logic [CNT_W-1:0]      CNT_FINAL  = CNT_W'(ROM_SIZE);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(ROM_SIZE - 1);
    localparam logic [ROM_ADDR_W-1:0] ADDR_LAST  = ROM_ADDR_W'(ROM_SIZE - 1);

    typedef enum logic [1:0] {
        ST_COPY_PENDING,
        ST_COPY,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    valid_reg, valid_next;
    logic [ROM_ADDR_W-1:0]   idx_reg, idx_next;
    logic [ROM_ADDR_W-1:0]   issue_addr;
    logic [3:0]              hdr_bad;
    logic                    magic_fail;

    // One comparator per header byte; only the one matching the current
    // byte index can flag a mismatch.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_magic
            assign hdr_bad[gi] = (32'(idx_reg) == gi) &&
                                 (rom_data != MAGIC[31-8*gi -: 8]);
        end
    endgenerate

    assign magic_fail = CHECK_MAGIC && valid_reg &&
                        (state_reg == ST_COPY) && (|hdr_bad);

    // Address issued to the ROM this cycle: saturates at the last byte so
    // the trailing write-only cycle never wraps back to address 0.
    assign issue_addr = (cnt_reg >= CNT_LAST) ? ADDR_LAST
                                              : cnt_reg[ROM_ADDR_W-1:0];

    // RAM side is a straight pass-through, offset by the delayed index.
    assign ram_data = rom_data;
    assign ram_addr = RAM_BASE + RAM_ADDR_W'(idx_reg);

    // State, counter and data-pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_COPY_PENDING;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state logic and Moore/Mealy outputs of the copy sequencer.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        valid_next = 1'b0;
        idx_next   = '0;
        rom_addr   = '0;
        rom_enable = 1'b0;
        ram_write  = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;

        case (state_reg)
            ST_COPY_PENDING: begin
                cnt_next   = '0;
                state_next = ST_COPY;
            end
            ST_COPY: begin
                rom_addr   = issue_addr;
                rom_enable = 1'b1;
                ram_write  = valid_reg && !magic_fail;
                if (magic_fail) begin
                    state_next = ST_ERROR;
                end else if (cnt_reg == CNT_FINAL) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                    valid_next = 1'b1;
                    idx_next   = issue_addr;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) begin
                    cnt_next   = '0;
                    state_next = ST_COPY_PENDING;
                end
            end
            ST_ERROR: begin
                error = 1'b1;
                if (start) begin
                    cnt_next   = '0;
                    state_next = ST_COPY_PENDING;
                end
            end
            default: begin
                state_next = ST_COPY_PENDING;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_boot_copier.sv
// Testbench for rom_boot_copier: three instances (default, header check
// disabled, small ROM with a wrapping RAM base) each fed by a ROM model,
// with a per-instance scoreboard of expected RAM writes.
module tb_rom_boot_copier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom_img [128];

    // Instance A: default parameters.
    logic        reset_a = 1'b1, start_a = 1'b0;
    logic [6:0]  rom_addr_a;
    logic        rom_enable_a;
    logic [7:0]  rom_data_a = 8'h00;
    logic [15:0] ram_addr_a;
    logic [7:0]  ram_data_a;
    logic        ram_write_a, cpu_reset_a, done_a, error_a;

    // Instance B: header check disabled.
    logic        reset_b = 1'b1, start_b = 1'b0;
    logic [6:0]  rom_addr_b;
    logic        rom_enable_b;
    logic [7:0]  rom_data_b = 8'h00;
    logic [15:0] ram_addr_b;
    logic [7:0]  ram_data_b;
    logic        ram_write_b, cpu_reset_b, done_b, error_b;

    // Instance C: 32-byte ROM copied to a base near the top of RAM.
    logic        reset_c = 1'b1, start_c = 1'b0;
    logic [4:0]  rom_addr_c;
    logic        rom_enable_c;
    logic [7:0]  rom_data_c = 8'h00;
    logic [15:0] ram_addr_c;
    logic [7:0]  ram_data_c;
    logic        ram_write_c, cpu_reset_c, done_c, error_c;

    logic [23:0] q_a [$];
    logic [23:0] q_b [$];
    logic [23:0] q_c [$];

    rom_boot_copier dut_a (
        .clk(clk), .reset(reset_a), .start(start_a),
        .rom_addr(rom_addr_a), .rom_enable(rom_enable_a), .rom_data(rom_data_a),
        .ram_addr(ram_addr_a), .ram_data(ram_data_a), .ram_write(ram_write_a),
        .cpu_reset(cpu_reset_a), .done(done_a), .error(error_a)
    );

    rom_boot_copier #(.CHECK_MAGIC(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b),
        .rom_addr(rom_addr_b), .rom_enable(rom_enable_b), .rom_data(rom_data_b),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b), .ram_write(ram_write_b),
        .cpu_reset(cpu_reset_b), .done(done_b), .error(error_b)
    );

    rom_boot_copier #(.ROM_ADDR_W(5), .ROM_SIZE(32), .RAM_BASE(16'hFFF0)) dut_c (
        .clk(clk), .reset(reset_c), .start(start_c),
        .rom_addr(rom_addr_c), .rom_enable(rom_enable_c), .rom_data(rom_data_c),
        .ram_addr(ram_addr_c), .ram_data(ram_data_c), .ram_write(ram_write_c),
        .cpu_reset(cpu_reset_c), .done(done_c), .error(error_c)
    );

    // Synchronous ROM models: registered read, output zero when disabled.
    always @(posedge clk) rom_data_a <= rom_enable_a ? rom_img[rom_addr_a] : 8'h00;
    always @(posedge clk) rom_data_b <= rom_enable_b ? rom_img[rom_addr_b] : 8'h00;
    always @(posedge clk) rom_data_c <= rom_enable_c ? rom_img[rom_addr_c] : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: every RAM write must match the oldest expected one.
    always @(negedge clk) begin
        if (ram_write_a === 1'b1) begin
            if (q_a.size() == 0) check("a_extra_write", 32'(q_a.size()), 32'd1);
            else check("a_write", 32'({ram_addr_a, ram_data_a}), 32'(q_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (ram_write_b === 1'b1) begin
            if (q_b.size() == 0) check("b_extra_write", 32'(q_b.size()), 32'd1);
            else check("b_write", 32'({ram_addr_b, ram_data_b}), 32'(q_b.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (ram_write_c === 1'b1) begin
            if (q_c.size() == 0) check("c_extra_write", 32'(q_c.size()), 32'd1);
            else check("c_write", 32'({ram_addr_c, ram_data_c}), 32'(q_c.pop_front()));
        end
    end

    task automatic push_a(input int n);
        for (int i = 0; i < n; i++) q_a.push_back({16'(i), rom_img[i]});
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_rom_addr"},   32'(rom_addr_a),   32'd0);
        check({tag, "_rom_enable"}, 32'(rom_enable_a), 32'd0);
        check({tag, "_ram_write"},  32'(ram_write_a),  32'd0);
        check({tag, "_ram_addr"},   32'(ram_addr_a),   32'd0);
        check({tag, "_cpu_reset"},  32'(cpu_reset_a),  32'd1);
        check({tag, "_done"},       32'(done_a),       32'd0);
        check({tag, "_error"},      32'(error_a),      32'd0);
    endtask

    // Full copy on A starting from COPY_PENDING: 130 edges to DONE, with
    // the ROM address checked every copy cycle and an optional stray start.
    task automatic run_a(input int pulse_at);
        for (int e = 1; e <= 130; e++) begin
            @(posedge clk);
            #1;
            start_a = (e == pulse_at) ? 1'b1 : 1'b0;
            if (e < 130) begin
                check("a_rom_enable", 32'(rom_enable_a), 32'd1);
                check("a_rom_addr", 32'(rom_addr_a), (e - 1 > 127) ? 32'd127 : 32'(e - 1));
            end
            if (e == 129) begin
                check("a_cpu_reset_before_done", 32'(cpu_reset_a), 32'd1);
                check("a_done_early", 32'(done_a), 32'd0);
            end
        end
        check("a_done", 32'(done_a), 32'd1);
        check("a_cpu_reset_released", 32'(cpu_reset_a), 32'd0);
        check("a_rom_enable_done", 32'(rom_enable_a), 32'd0);
        check("a_error_clear", 32'(error_a), 32'd0);
        check("a_sb_empty", 32'(q_a.size()), 32'd0);
    endtask

    initial begin
        rom_img[0] = 8'h41;
        rom_img[1] = 8'h53;
        rom_img[2] = 8'h52;
        rom_img[3] = 8'h4D;
        for (int i = 4; i < 128; i++) rom_img[i] = 8'($urandom_range(255, 0));

        repeat (3) @(negedge clk);
        check_reset_a("a_reset");

        // Good image: 128 writes, DONE 130 edges after release.
        push_a(128);
        @(negedge clk);
        reset_a = 1'b0;
        run_a(0);
        $display("step good_copy: checks=%0d errors=%0d", checks, errors);

        // Restart from DONE with a stray start pulse mid-copy.
        push_a(128);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("a_restart_cpu_reset", 32'(cpu_reset_a), 32'd1);
        check("a_restart_done", 32'(done_a), 32'd0);
        run_a(20);
        $display("step restart_copy: checks=%0d errors=%0d", checks, errors);

        // Asynchronous reset in copy cycle 50, then a clean rerun.
        push_a(49);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (51) @(posedge clk);
        #1;
        check("a_mid_in_copy", 32'(rom_enable_a), 32'd1);
        reset_a = 1'b1;
        #1;
        check_reset_a("a_mid_reset");
        check("a_mid_sb_empty", 32'(q_a.size()), 32'd0);
        push_a(128);
        @(negedge clk);
        reset_a = 1'b0;
        run_a(0);
        $display("step reset_mid_copy: checks=%0d errors=%0d", checks, errors);

        // Bad header byte 2: only bytes 0 and 1 are written, then ERROR.
        rom_img[2] = 8'h00;
        push_a(2);
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("a_bad_byte_no_write", 32'(ram_write_a), 32'd0);
        check("a_bad_no_error_yet", 32'(error_a), 32'd0);
        @(posedge clk);
        #1;
        check("a_bad_error", 32'(error_a), 32'd1);
        check("a_bad_cpu_reset", 32'(cpu_reset_a), 32'd1);
        check("a_bad_done", 32'(done_a), 32'd0);
        check("a_bad_rom_enable", 32'(rom_enable_a), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("a_bad_error_held", 32'(error_a), 32'd1);
        check("a_bad_sb_empty", 32'(q_a.size()), 32'd0);

        // Start from ERROR clears it and retries, failing the same way.
        push_a(2);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("a_err_restart_error", 32'(error_a), 32'd0);
        check("a_err_restart_cpu_reset", 32'(cpu_reset_a), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("a_err_rerun_error", 32'(error_a), 32'd1);
        check("a_err_rerun_sb_empty", 32'(q_a.size()), 32'd0);
        $display("step bad_magic: checks=%0d errors=%0d", checks, errors);

        // Header check disabled: bad image still copies completely.
        for (int i = 0; i < 128; i++) q_b.push_back({16'(i), rom_img[i]});
        @(negedge clk);
        reset_b = 1'b0;
        repeat (129) @(posedge clk);
        #1;
        check("b_cpu_reset_before_done", 32'(cpu_reset_b), 32'd1);
        @(posedge clk);
        #1;
        check("b_done", 32'(done_b), 32'd1);
        check("b_cpu_reset_released", 32'(cpu_reset_b), 32'd0);
        check("b_error", 32'(error_b), 32'd0);
        check("b_sb_empty", 32'(q_b.size()), 32'd0);
        $display("step no_magic_check: checks=%0d errors=%0d", checks, errors);

        // 32-byte ROM at base FFF0: RAM address wraps after FFFF.
        rom_img[2] = 8'h52;
        for (int i = 0; i < 32; i++) q_c.push_back({16'hFFF0 + 16'(i), rom_img[i]});
        @(negedge clk);
        reset_c = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        check("c_cpu_reset_before_done", 32'(cpu_reset_c), 32'd1);
        @(posedge clk);
        #1;
        check("c_done", 32'(done_c), 32'd1);
        check("c_cpu_reset_released", 32'(cpu_reset_c), 32'd0);
        check("c_sb_empty", 32'(q_c.size()), 32'd0);
        $display("step ram_wrap: checks=%0d errors=%0d", checks, errors);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
